// File: rtl/bus_arbiter.sv
// Round-robin arbiter: N_MASTERS simple-bus masters share one slave port. A grant lasts one transaction.
// Latency: request to o_bus_en is 1 cycle; slave ack to o_m_ack is 0 cycles; at least 1 idle cycle between grants.
// Backpressure: the owner keeps the bus until ack or timeout abort; other requesters hold bus_en high and wait their turn.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_m_bus_en,
    input  logic [N_MASTERS-1:0]      i_m_wr_en,
    input  logic [32*N_MASTERS-1:0]   i_m_wr_data,
    input  logic [32*N_MASTERS-1:0]   i_m_addr,
    input  logic [4*N_MASTERS-1:0]    i_m_byte_en,
    output logic [N_MASTERS-1:0]      o_m_ack,
    output logic [N_MASTERS-1:0]      o_m_err,
    output logic [31:0]               o_m_rd_data,
    output logic [N_MASTERS-1:0]      o_grant,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [31:0]               o_wr_data,
    output logic [31:0]               o_addr,
    output logic [3:0]                o_byte_en,
    input  logic                      i_ack,
    input  logic [31:0]               i_rd_data
);
    localparam int                   IDX_W    = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE      = N_MASTERS'(1);
    localparam int                   TO_M1    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [15:0]          TO_LIM   = 16'(TO_M1);
    localparam bit                   TO_EN    = (TIMEOUT != 0);
    localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(N_MASTERS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_last_idx;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W-1:0]     w_cand_idx;
    logic                 w_win_found;
    int                   w_cand;
    logic [15:0]          r_tcnt;
    logic [N_MASTERS-1:0] r_grant;
    logic                 r_bus_en;
    logic                 r_wr_en;
    logic [31:0]          r_wr_data;
    logic [31:0]          r_addr;
    logic [3:0]           r_byte_en;
    logic                 w_ack_now;
    logic                 w_to_now;
    logic                 w_done;

    // Round-robin search: first requester strictly after the previous owner, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = 0;
        w_cand_idx  = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_cand     = (int'(r_last_idx) + k) % N_MASTERS;
            w_cand_idx = IDX_W'(w_cand);
            if (!w_win_found && i_m_bus_en[w_cand_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand_idx;
            end
        end
    end

    // Next state and zero-latency completion pulses; a real ack beats a coincident timeout.
    always_comb begin
        w_next    = r_state;
        w_ack_now = (r_state == BUSY) && i_ack;
        w_to_now  = TO_EN && (r_state == BUSY) && !i_ack && (r_tcnt == TO_LIM);
        w_done    = w_ack_now || w_to_now;
        o_m_ack   = '0;
        o_m_err   = '0;
        case (r_state)
            IDLE: if (w_win_found) w_next = BUSY;
            BUSY: if (w_done)      w_next = IDLE;
            default:               w_next = IDLE;
        endcase
        if (w_done)   o_m_ack = ONE << r_grant_idx;
        if (w_to_now) o_m_err = ONE << r_grant_idx;
    end

    // FSM state register; reset abandons any open transaction without acking it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Grant bookkeeping and slave-side registers: latched at grant, frozen while BUSY.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant_idx <= '0;
            r_last_idx  <= LAST_RST;
            r_tcnt      <= '0;
            r_grant     <= '0;
            r_bus_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_byte_en   <= '0;
        end else if (r_state == IDLE) begin
            r_bus_en <= 1'b0;
            if (w_win_found) begin
                r_bus_en    <= 1'b1;
                r_wr_en     <= i_m_wr_en[w_win_idx];
                r_wr_data   <= i_m_wr_data[32*w_win_idx +: 32];
                r_addr      <= i_m_addr[32*w_win_idx +: 32];
                r_byte_en   <= i_m_byte_en[4*w_win_idx +: 4];
                r_grant     <= ONE << w_win_idx;
                r_grant_idx <= w_win_idx;
                r_tcnt      <= '0;
            end
        end else if (w_done) begin
            r_bus_en   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_grant    <= '0;
            r_last_idx <= r_grant_idx;
        end else if (r_tcnt != 16'hFFFF) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    assign o_m_rd_data = i_rd_data;
    assign o_grant     = r_grant;
    assign o_bus_en    = r_bus_en;
    assign o_wr_en     = r_wr_en;
    assign o_wr_data   = r_wr_data;
    assign o_addr      = r_addr;
    assign o_byte_en   = r_byte_en;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two masters, TIMEOUT=8, directed scenarios.
// Expected acks are queued with their cycle number; a negedge monitor pops and compares.
// Register outputs are checked directly 1 time unit after the rising edge.
module tb_bus_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_m_bus_en;
    logic [1:0]  i_m_wr_en;
    logic [63:0] i_m_wr_data;
    logic [63:0] i_m_addr;
    logic [7:0]  i_m_byte_en;
    logic [1:0]  o_m_ack;
    logic [1:0]  o_m_err;
    logic [31:0] o_m_rd_data;
    logic [1:0]  o_grant;
    logic        o_bus_en;
    logic        o_wr_en;
    logic [31:0] o_wr_data;
    logic [31:0] o_addr;
    logic [3:0]  o_byte_en;
    logic        i_ack;
    logic [31:0] i_rd_data;

    always #5 i_clk = ~i_clk;

    bus_arbiter #(.N_MASTERS(2), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m_bus_en(i_m_bus_en), .i_m_wr_en(i_m_wr_en), .i_m_wr_data(i_m_wr_data),
        .i_m_addr(i_m_addr), .i_m_byte_en(i_m_byte_en),
        .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_rd_data(o_m_rd_data),
        .o_grant(o_grant), .o_bus_en(o_bus_en), .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data), .o_addr(o_addr), .o_byte_en(o_byte_en),
        .i_ack(i_ack), .i_rd_data(i_rd_data)
    );

    typedef struct {
        int          cyc;
        int          m;
        bit          err;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wdat;
        bit          we;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int m, input bit err, input logic [31:0] rd,
                        input logic [31:0] addr, input logic [31:0] wdat, input bit we);
        exp_t e;
        e.cyc = cyc; e.m = m; e.err = err; e.rd = rd; e.addr = addr; e.wdat = wdat; e.we = we;
        sb.push_back(e);
    endtask

    // Monitor: every ack pulse must match the head of the queue, in the expected cycle.
    always @(negedge i_clk) begin
        exp_t e;
        if (|o_m_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=%b err=%b required no ack (cycle %0d)", o_m_ack, o_m_err, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_vec", {30'd0, o_m_ack}, 1 << e.m);
                chk("err_vec", {30'd0, o_m_err}, e.err ? (1 << e.m) : 0);
                chk("rd_data", o_m_rd_data, e.rd);
                chk("ack_addr", o_addr, e.addr);
                chk("ack_wr_en", {31'd0, o_wr_en}, {31'd0, e.we});
                if (e.we) chk("ack_wr_data", o_wr_data, e.wdat);
            end
        end else if (|o_m_err) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_without_ack: got err=%b required 00 (cycle %0d)", o_m_err, cyc);
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_ack: got ack=00 required master %0d ack in cycle %0d", e.m, e.cyc);
        end
    end

    // Guards against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_m_bus_en = '0; i_m_wr_en = '0; i_m_wr_data = '0;
        i_m_addr = '0; i_m_byte_en = '0; i_ack = 1'b0; i_rd_data = '0;
        #2 i_rst = 1'b0;
        #1;
        chk("rst_bus_en", {31'd0, o_bus_en}, 0);
        chk("rst_grant", {30'd0, o_grant}, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_byte_en", {28'd0, o_byte_en}, 0);
        chk("rst_ack", {30'd0, o_m_ack}, 0);
        repeat (2) tick();
        i_rst = 1'b1;

        // Single read by master 0, acked in the 3rd BUSY cycle.
        i_m_bus_en = 2'b01; i_m_wr_en = 2'b00; i_m_addr[31:0] = 32'h100; i_m_byte_en[3:0] = 4'hF;
        tick();
        chk("rd_bus_en", {31'd0, o_bus_en}, 1);
        chk("rd_addr", o_addr, 32'h100);
        chk("rd_grant", {30'd0, o_grant}, 1);
        chk("rd_byte_en", {28'd0, o_byte_en}, 32'hF);
        tick();
        tick();
        i_ack = 1'b1; i_rd_data = 32'hDEADBEEF;
        push(0, 1'b0, 32'hDEADBEEF, 32'h100, 32'h0, 1'b0);
        tick();
        i_ack = 1'b0; i_m_bus_en = 2'b00;
        chk("rd_bus_en_after", {31'd0, o_bus_en}, 0);
        chk("rd_grant_after", {30'd0, o_grant}, 0);

        // Contention from reset: both masters write continuously, expect 0,1,0,1.
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        i_m_wr_en = 2'b11; i_m_wr_data = {32'h22, 32'h11};
        i_m_addr = {32'h300, 32'h200}; i_m_byte_en = 8'hFF; i_m_bus_en = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rr_grant", {30'd0, o_grant}, 1 << (t % 2));
            chk("rr_wr_data", o_wr_data, (t % 2) ? 32'h22 : 32'h11);
            i_ack = 1'b1; i_rd_data = 32'(t);
            push(t % 2, 1'b0, 32'(t), (t % 2) ? 32'h300 : 32'h200, (t % 2) ? 32'h22 : 32'h11, 1'b1);
            tick();
            i_ack = 1'b0;
            chk("rr_gap_bus_en", {31'd0, o_bus_en}, 0);
        end

        // Input stability: master 1 changes address and drops its request mid-transaction.
        i_m_bus_en = 2'b10; i_m_wr_en = 2'b00; i_m_addr[63:32] = 32'h400;
        tick();
        chk("stab_grant", {30'd0, o_grant}, 32'h2);
        chk("stab_addr1", o_addr, 32'h400);
        i_m_addr[63:32] = 32'h4FC;
        tick();
        chk("stab_addr2", o_addr, 32'h400);
        tick();
        i_m_bus_en = 2'b00;
        i_ack = 1'b1; i_rd_data = 32'h12345678;
        push(1, 1'b0, 32'h12345678, 32'h400, 32'h0, 1'b0);
        tick();
        i_ack = 1'b0;

        // Timeout: master 0 writes, slave never acks; abort in BUSY cycle 8.
        i_m_bus_en = 2'b01; i_m_wr_en = 2'b01; i_m_addr[31:0] = 32'h500;
        i_m_wr_data[31:0] = 32'hAA; i_rd_data = 32'hBAD0BAD0;
        tick();
        chk("to_grant", {30'd0, o_grant}, 1);
        repeat (7) tick();
        push(0, 1'b1, 32'hBAD0BAD0, 32'h500, 32'hAA, 1'b1);
        tick();
        i_m_bus_en = 2'b00;
        chk("to_idle_bus_en", {31'd0, o_bus_en}, 0);
        chk("to_idle_grant", {30'd0, o_grant}, 0);
        i_ack = 1'b1;
        #3;
        chk("stray_ack", {30'd0, o_m_ack}, 0);
        chk("stray_err", {30'd0, o_m_err}, 0);
        tick();
        i_ack = 1'b0;

        // Ack and timeout threshold in the same cycle: ack wins, no error.
        i_m_bus_en = 2'b10; i_m_addr[63:32] = 32'h600;
        tick();
        chk("tie_grant", {30'd0, o_grant}, 32'h2);
        repeat (7) tick();
        i_ack = 1'b1; i_rd_data = 32'hCAFEF00D;
        push(1, 1'b0, 32'hCAFEF00D, 32'h600, 32'h0, 1'b0);
        tick();
        i_ack = 1'b0; i_m_bus_en = 2'b00;

        // Make master 0 the last owner, then reset while master 1 is BUSY.
        i_m_bus_en = 2'b01; i_rd_data = 32'h5;
        tick();
        i_ack = 1'b1;
        push(0, 1'b0, 32'h5, 32'h500, 32'hAA, 1'b1);
        tick();
        i_ack = 1'b0; i_m_bus_en = 2'b10;
        tick();
        chk("pre_rst_grant", {30'd0, o_grant}, 32'h2);
        #2;
        i_rst = 1'b0; i_ack = 1'b1;
        #1;
        chk("mid_rst_bus_en", {31'd0, o_bus_en}, 0);
        chk("mid_rst_grant", {30'd0, o_grant}, 0);
        chk("mid_rst_addr", o_addr, 0);
        chk("mid_rst_byte_en", {28'd0, o_byte_en}, 0);
        chk("mid_rst_ack", {30'd0, o_m_ack}, 0);
        tick();
        i_rst = 1'b1; i_ack = 1'b0; i_m_bus_en = 2'b11; i_rd_data = 32'h0BADCAFE;
        tick();
        chk("post_rst_grant", {30'd0, o_grant}, 1);
        i_ack = 1'b1;
        push(0, 1'b0, 32'h0BADCAFE, 32'h500, 32'hAA, 1'b1);
        tick();
        i_ack = 1'b0; i_m_bus_en = 2'b00;
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
